layer_sched: RTL and testbench

Sequencer for the stacked platform layers of the playfield. Holds a ring of LAYERS layer descriptors (block presence, block type, bonus), fetches new descriptors from the level generator over a req/ack handshake, and advances a per-frame scroll offset. Its per-slot map, ypos and valid outputs drive the `module_en`, `layer_map`, `block_type`, `bonus_map` and `ypos` inputs of the per-layer draw stages in the VGA chain.

---
 rtl/layer_sched_pkg.sv | 22 ++
 rtl/layer_ring.sv | 76 +++++++
 rtl/layer_sched.sv | 193 +++++++++++++++++++
 tb/tb_layer_sched.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/layer_sched_pkg.sv
// Shared types and default geometry for the playfield layer sequencer.
// Optional feature macro used by this slice: LAYER_SCHED_BONUS_EN.
package layer_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_RUN   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_FETCH = 3'd4
  } state_e;

  localparam int DESC_W      = 7;
  localparam int OFFSET_W    = 8;
  localparam int YPOS_W      = 12;
  localparam int RETIRED_W   = 16;

  localparam int LAYER_PITCH = 150;
  localparam int SCROLL_STEP = 2;
  localparam int BOTTOM_Y    = 650;

endpackage

// File: rtl/layer_ring.sv
// LAYERS-deep descriptor ring: indexed write, shift toward slot 0, per-slot valid.
// Bonus storage exists only when LAYER_SCHED_BONUS_EN is defined.
module layer_ring #(
  parameter int LAYERS = 4,
  parameter int IDX_W  = 2
) (
  input  logic                                      pclk,
  input  logic                                      rst,
  input  logic                                      wr_en,
  input  logic [IDX_W-1:0]                          wr_idx,
  input  logic [layer_sched_pkg::DESC_W-1:0]        map_in,
  input  logic [layer_sched_pkg::DESC_W-1:0]        type_in,
  input  logic [layer_sched_pkg::DESC_W-1:0]        bonus_in,
  input  logic                                      shift_en,
  input  logic                                      clr_valid,
  output logic [LAYERS*layer_sched_pkg::DESC_W-1:0] map_out,
  output logic [LAYERS*layer_sched_pkg::DESC_W-1:0] type_out,
  output logic [LAYERS*layer_sched_pkg::DESC_W-1:0] bonus_out,
  output logic [LAYERS-1:0]                         valid_out
);
  import layer_sched_pkg::*;

  localparam int RING_W = LAYERS * DESC_W;

  logic [RING_W-1:0] map_r;
  logic [RING_W-1:0] type_r;
  logic [LAYERS-1:0] valid_r;

  // Map/type storage and valid bits; clear beats shift beats write.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      map_r   <= {RING_W{1'b0}};
      type_r  <= {RING_W{1'b0}};
      valid_r <= {LAYERS{1'b0}};
    end else if (clr_valid) begin
      valid_r <= {LAYERS{1'b0}};
    end else if (shift_en) begin
      map_r   <= {{DESC_W{1'b0}}, map_r[RING_W-1:DESC_W]};
      type_r  <= {{DESC_W{1'b0}}, type_r[RING_W-1:DESC_W]};
      valid_r <= {1'b0, valid_r[LAYERS-1:1]};
    end else if (wr_en) begin
      map_r[wr_idx*DESC_W +: DESC_W]  <= map_in;
      type_r[wr_idx*DESC_W +: DESC_W] <= type_in;
      valid_r[wr_idx]                 <= 1'b1;
    end
  end

`ifdef LAYER_SCHED_BONUS_EN
  logic [RING_W-1:0] bonus_r;

  // Bonus storage follows the same write/shift rules as the map.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      bonus_r <= {RING_W{1'b0}};
    end else if (clr_valid) begin
      bonus_r <= bonus_r;
    end else if (shift_en) begin
      bonus_r <= {{DESC_W{1'b0}}, bonus_r[RING_W-1:DESC_W]};
    end else if (wr_en) begin
      bonus_r[wr_idx*DESC_W +: DESC_W] <= bonus_in;
    end
  end

  assign bonus_out = bonus_r;
`else
  logic unused_bonus_s;

  assign unused_bonus_s = ^bonus_in;
  assign bonus_out      = {RING_W{1'b0}};
`endif

  assign map_out   = map_r;
  assign type_out  = type_r;
  assign valid_out = valid_r;

endmodule

// File: rtl/layer_sched.sv
// Platform layer sequencer: fills/refills the layer ring and scrolls per frame.
// LAYER_SCHED_BONUS_EN enables bonus-map storage in the ring.
module layer_sched #(
  parameter int LAYERS      = 4,
  parameter int LAYER_PITCH = layer_sched_pkg::LAYER_PITCH,
  parameter int SCROLL_STEP = layer_sched_pkg::SCROLL_STEP,
  parameter int BOTTOM_Y    = layer_sched_pkg::BOTTOM_Y
) (
  input  logic                                      pclk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic                                      stop,
  input  logic                                      scroll_en,
  input  logic                                      vsync,
  output logic                                      layer_req,
  input  logic                                      layer_ack,
  input  logic [layer_sched_pkg::DESC_W-1:0]        layer_map_in,
  input  logic [layer_sched_pkg::DESC_W-1:0]        block_type_in,
  input  logic [layer_sched_pkg::DESC_W-1:0]        bonus_map_in,
  output logic [LAYERS*layer_sched_pkg::DESC_W-1:0] layer_map_out,
  output logic [LAYERS*layer_sched_pkg::DESC_W-1:0] block_type_out,
  output logic [LAYERS*layer_sched_pkg::DESC_W-1:0] bonus_map_out,
  output logic [LAYERS*layer_sched_pkg::YPOS_W-1:0] ypos_out,
  output logic [LAYERS-1:0]                         layer_valid,
  output logic                                      busy,
  output logic                                      frame_overrun,
  output logic [layer_sched_pkg::RETIRED_W-1:0]     retired_count
);
  import layer_sched_pkg::*;

  localparam int IDX_W = (LAYERS > 1) ? $clog2(LAYERS) : 1;
  localparam int SUM_W = OFFSET_W + 1;

  state_e                     state_r;
  logic [IDX_W-1:0]           fill_cnt_r;
  logic                       vsync_prev_r;
  logic [OFFSET_W-1:0]        offset_r;
  logic [LAYERS*YPOS_W-1:0]   ypos_r;
  logic                       layer_req_r;
  logic                       busy_r;
  logic                       frame_overrun_r;
  logic [RETIRED_W-1:0]       retired_count_r;

  logic                       tick_s;
  logic                       ack_ok_s;
  logic                       start_ok_s;
  logic                       scroll_s;
  logic                       wrap_s;
  logic [SUM_W-1:0]           sum_s;
  logic [OFFSET_W-1:0]        offset_nxt_s;
  logic                       wr_en_s;
  logic [IDX_W-1:0]           wr_idx_s;
  logic                       shift_en_s;

  // Event decode and next-offset arithmetic; stop suppresses every action.
  always_comb begin
    tick_s     = vsync & ~vsync_prev_r;
    ack_ok_s   = layer_ack & layer_req_r & ~stop;
    start_ok_s = start & ~stop & (state_r == ST_IDLE);
    scroll_s   = tick_s & scroll_en & ~stop & (state_r == ST_RUN);
    sum_s      = {1'b0, offset_r} + SUM_W'(SCROLL_STEP);
    wrap_s     = (sum_s >= SUM_W'(LAYER_PITCH));
    if (start_ok_s) begin
      offset_nxt_s = {OFFSET_W{1'b0}};
    end else if (scroll_s) begin
      if (wrap_s) begin
        offset_nxt_s = OFFSET_W'(sum_s - SUM_W'(LAYER_PITCH));
      end else begin
        offset_nxt_s = OFFSET_W'(sum_s);
      end
    end else begin
      offset_nxt_s = offset_r;
    end
    wr_en_s    = ack_ok_s & ((state_r == ST_FILL) | (state_r == ST_FETCH));
    wr_idx_s   = (state_r == ST_FILL) ? fill_cnt_r : IDX_W'(LAYERS - 1);
    shift_en_s = (state_r == ST_SHIFT) & ~stop;
  end

  // Scroll offset and per-slot ypos, updated on the same edge.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      offset_r <= {OFFSET_W{1'b0}};
      ypos_r   <= {(LAYERS*YPOS_W){1'b0}};
    end else begin
      offset_r <= offset_nxt_s;
      if ((state_r != ST_IDLE) || start_ok_s) begin
        for (int k = 0; k < LAYERS; k++) begin
          ypos_r[k*YPOS_W +: YPOS_W] <= YPOS_W'(BOTTOM_Y - k * LAYER_PITCH) + YPOS_W'(offset_nxt_s);
        end
      end
    end
  end

  // Sequencer FSM with registered handshake and status outputs.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      state_r         <= ST_IDLE;
      fill_cnt_r      <= {IDX_W{1'b0}};
      vsync_prev_r    <= 1'b0;
      layer_req_r     <= 1'b0;
      busy_r          <= 1'b0;
      frame_overrun_r <= 1'b0;
      retired_count_r <= {RETIRED_W{1'b0}};
    end else begin
      vsync_prev_r <= vsync;
      if (stop) begin
        state_r     <= ST_IDLE;
        layer_req_r <= 1'b0;
        busy_r      <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start) begin
              state_r         <= ST_FILL;
              fill_cnt_r      <= {IDX_W{1'b0}};
              retired_count_r <= {RETIRED_W{1'b0}};
              frame_overrun_r <= 1'b0;
              busy_r          <= 1'b1;
            end
          end
          ST_FILL: begin
            if (ack_ok_s) begin
              layer_req_r <= 1'b0;
              fill_cnt_r  <= fill_cnt_r + IDX_W'(1);
              if (fill_cnt_r == IDX_W'(LAYERS - 1)) begin
                state_r <= ST_RUN;
                busy_r  <= 1'b0;
              end
            end else begin
              layer_req_r <= 1'b1;
            end
          end
          ST_RUN: begin
            if (scroll_s && wrap_s) begin
              state_r <= ST_SHIFT;
              busy_r  <= 1'b1;
            end
          end
          ST_SHIFT: begin
            retired_count_r <= retired_count_r + RETIRED_W'(1);
            state_r         <= ST_FETCH;
            if (tick_s) begin
              frame_overrun_r <= 1'b1;
            end
          end
          ST_FETCH: begin
            if (tick_s) begin
              frame_overrun_r <= 1'b1;
            end
            if (ack_ok_s) begin
              layer_req_r <= 1'b0;
              state_r     <= ST_RUN;
              busy_r      <= 1'b0;
            end else begin
              layer_req_r <= 1'b1;
            end
          end
          default: begin
            state_r     <= ST_IDLE;
            layer_req_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        endcase
      end
    end
  end

  layer_ring #(
    .LAYERS (LAYERS),
    .IDX_W  (IDX_W)
  ) u_ring (
    .pclk      (pclk),
    .rst       (rst),
    .wr_en     (wr_en_s),
    .wr_idx    (wr_idx_s),
    .map_in    (layer_map_in),
    .type_in   (block_type_in),
    .bonus_in  (bonus_map_in),
    .shift_en  (shift_en_s),
    .clr_valid (stop),
    .map_out   (layer_map_out),
    .type_out  (block_type_out),
    .bonus_out (bonus_map_out),
    .valid_out (layer_valid)
  );

  assign layer_req     = layer_req_r;
  assign busy          = busy_r;
  assign frame_overrun = frame_overrun_r;
  assign retired_count = retired_count_r;
  assign ypos_out      = ypos_r;

endmodule

// File: tb/tb_layer_sched.sv
// Directed self-checking bench for layer_sched with default geometry.
module tb_layer_sched;

  logic        pclk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        scroll_en = 1'b0;
  logic        vsync = 1'b0;
  logic        layer_ack = 1'b0;
  logic [6:0]  layer_map_in = 7'd0;
  logic [6:0]  block_type_in = 7'd0;
  logic [6:0]  bonus_map_in = 7'd0;
  logic        layer_req;
  logic [27:0] layer_map_out;
  logic [27:0] block_type_out;
  logic [27:0] bonus_map_out;
  logic [47:0] ypos_out;
  logic [3:0]  layer_valid;
  logic        busy;
  logic        frame_overrun;
  logic [15:0] retired_count;

  int n_vec = 0;
  int n_miscomp = 0;
  int req_rises = 0;

  localparam logic [47:0] YPOS_BASE = {12'd200, 12'd350, 12'd500, 12'd650};
  localparam logic [47:0] YPOS_OFS2 = {12'd202, 12'd352, 12'd502, 12'd652};
`ifdef LAYER_SCHED_BONUS_EN
  localparam logic [27:0] BONUS_FULL = {4{7'h7F}};
`else
  localparam logic [27:0] BONUS_FULL = 28'd0;
`endif

  layer_sched dut (
    .pclk           (pclk),
    .rst            (rst),
    .start          (start),
    .stop           (stop),
    .scroll_en      (scroll_en),
    .vsync          (vsync),
    .layer_req      (layer_req),
    .layer_ack      (layer_ack),
    .layer_map_in   (layer_map_in),
    .block_type_in  (block_type_in),
    .bonus_map_in   (bonus_map_in),
    .layer_map_out  (layer_map_out),
    .block_type_out (block_type_out),
    .bonus_map_out  (bonus_map_out),
    .ypos_out       (ypos_out),
    .layer_valid    (layer_valid),
    .busy           (busy),
    .frame_overrun  (frame_overrun),
    .retired_count  (retired_count)
  );

  always #5 pclk = ~pclk;

  always @(posedge layer_req) req_rises++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscomp++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic frame();
    vsync = 1'b1;
    cycles(4);
    vsync = 1'b0;
    cycles(4);
  endtask

  task automatic deliver(input logic [6:0] m, input logic [6:0] t, input logic [6:0] b, input int dly);
    int waited = 0;
    while (layer_req !== 1'b1 && waited < 50) begin
      @(negedge pclk);
      waited++;
    end
    if (layer_req !== 1'b1) begin
      check("req_timeout", 64'(layer_req), 64'd1);
    end else begin
      cycles(dly);
      layer_map_in  = m;
      block_type_in = t;
      bonus_map_in  = b;
      layer_ack     = 1'b1;
      cycles(1);
      layer_ack     = 1'b0;
    end
  endtask

  initial begin
    cycles(3);
    check("rst_req",     64'(layer_req),     64'd0);
    check("rst_valid",   64'(layer_valid),   64'd0);
    check("rst_busy",    64'(busy),          64'd0);
    check("rst_ypos",    64'(ypos_out),      64'd0);
    check("rst_retired", 64'(retired_count), 64'd0);
    check("rst_overrun", 64'(frame_overrun), 64'd0);
    check("rst_map",     64'(layer_map_out), 64'd0);

    rst = 1'b1;
    cycles(1);
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    check("fill_busy", 64'(busy), 64'd1);
    deliver(7'h01, 7'h11, 7'h7F, 3);
    deliver(7'h02, 7'h12, 7'h7F, 3);
    deliver(7'h04, 7'h13, 7'h7F, 3);
    deliver(7'h08, 7'h14, 7'h7F, 3);
    cycles(2);
    check("fill_map",   64'(layer_map_out),  64'({7'h08, 7'h04, 7'h02, 7'h01}));
    check("fill_type",  64'(block_type_out), 64'({7'h14, 7'h13, 7'h12, 7'h11}));
    check("fill_bonus", 64'(bonus_map_out),  64'(BONUS_FULL));
    check("fill_valid", 64'(layer_valid),    64'hF);
    check("fill_run",   64'(busy),           64'd0);
    check("fill_req",   64'(layer_req),      64'd0);
    check("fill_ypos",  64'(ypos_out),       64'(YPOS_BASE));

    scroll_en = 1'b1;
    req_rises = 0;
    repeat (74) frame();
    check("scroll74_ypos0", 64'(ypos_out[11:0]), 64'd798);
    check("scroll74_ret",   64'(retired_count),  64'd0);
    frame();
    check("wrap_ypos",    64'(ypos_out),            64'(YPOS_BASE));
    check("wrap_retired", 64'(retired_count),       64'd1);
    check("wrap_reqrise", 64'(req_rises),           64'd1);
    check("wrap_req",     64'(layer_req),           64'd1);
    check("wrap_busy",    64'(busy),                64'd1);
    check("wrap_valid",   64'(layer_valid),         64'h7);
    check("wrap_slots",   64'(layer_map_out[20:0]), 64'({7'h08, 7'h04, 7'h02}));
    check("wrap_overrun", 64'(frame_overrun),       64'd0);

    frame();
    frame();
    check("ovr_flag", 64'(frame_overrun), 64'd1);
    check("ovr_ypos", 64'(ypos_out),      64'(YPOS_BASE));
    check("ovr_busy", 64'(busy),          64'd1);
    deliver(7'h10, 7'h15, 7'h7F, 1);
    cycles(2);
    check("fetch_valid", 64'(layer_valid),   64'hF);
    check("fetch_map",   64'(layer_map_out), 64'({7'h10, 7'h08, 7'h04, 7'h02}));
    check("fetch_busy",  64'(busy),          64'd0);
    check("fetch_req",   64'(layer_req),     64'd0);

    scroll_en = 1'b0;
    frame();
    check("noscroll_ypos", 64'(ypos_out), 64'(YPOS_BASE));
    scroll_en = 1'b1;
    frame();
    check("scroll1_ypos", 64'(ypos_out), 64'(YPOS_OFS2));
    scroll_en = 1'b0;
    frame();
    check("noscroll2_ypos", 64'(ypos_out), 64'(YPOS_OFS2));

    scroll_en = 1'b1;
    repeat (74) frame();
    check("fetch2_busy",    64'(busy),          64'd1);
    check("fetch2_req",     64'(layer_req),     64'd1);
    check("fetch2_retired", 64'(retired_count), 64'd2);

    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
    check("stop_valid",   64'(layer_valid),         64'd0);
    check("stop_req",     64'(layer_req),           64'd0);
    check("stop_busy",    64'(busy),                64'd0);
    check("stop_retired", 64'(retired_count),       64'd2);
    check("stop_map",     64'(layer_map_out[20:0]), 64'({7'h10, 7'h08, 7'h04}));

    layer_map_in = 7'h55;
    layer_ack    = 1'b1;
    cycles(1);
    layer_ack    = 1'b0;
    cycles(1);
    check("lateack_valid", 64'(layer_valid),         64'd0);
    check("lateack_map",   64'(layer_map_out[20:0]), 64'({7'h10, 7'h08, 7'h04}));
    check("lateack_busy",  64'(busy),                64'd0);

    start = 1'b1;
    stop  = 1'b1;
    cycles(1);
    start = 1'b0;
    stop  = 1'b0;
    cycles(2);
    check("startstop_busy", 64'(busy),      64'd0);
    check("startstop_req",  64'(layer_req), 64'd0);

    start = 1'b1;
    cycles(1);
    start = 1'b0;
    check("restart_busy", 64'(busy), 64'd1);
    deliver(7'h11, 7'h01, 7'h7F, 0);
    deliver(7'h22, 7'h02, 7'h7F, 0);
    deliver(7'h33, 7'h03, 7'h7F, 0);
    deliver(7'h44, 7'h04, 7'h7F, 0);
    cycles(2);
    check("refill_valid",   64'(layer_valid),   64'hF);
    check("refill_map",     64'(layer_map_out), 64'({7'h44, 7'h33, 7'h22, 7'h11}));
    check("refill_retired", 64'(retired_count), 64'd0);
    check("refill_overrun", 64'(frame_overrun), 64'd0);
    check("refill_ypos",    64'(ypos_out),      64'(YPOS_BASE));
    check("refill_busy",    64'(busy),          64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscomp);
    $finish;
  end

endmodule
